// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: I/O page offsets and STATUS bit layout.
// Optional bus-error reporting is enabled by defining DMEM_BUS_ERR_EN.
package dmem_pkg;

   localparam logic [7:0] FIFO_DATA_OFS = 8'd0;
   localparam logic [7:0] STATUS_OFS    = 8'd1;
   localparam logic [7:0] CYCLE_OFS     = 8'd2;

   localparam int ST_OVF_BIT   = 15;
   localparam int ST_FULL_BIT  = 14;
   localparam int ST_EMPTY_BIT = 13;
   localparam int ST_BERR_BIT  = 12;
   localparam int ST_CNT_W     = 5;

endpackage

// File: rtl/dmem_out_fifo.sv
// Output FIFO drained over a valid/ready stream; keeps a sticky overflow flag for dropped pushes.
// Storage is not reset, only pointers/count/flag are.
module dmem_out_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_ready,
   input  logic          i_ovf_clr,
   output logic [W-1:0]  o_data,
   output logic          o_valid,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_ovf
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [W-1:0]  r_mem [0:DEPTH-1];
   logic [AW-1:0] r_rptr;
   logic [AW-1:0] r_wptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;

   logic w_pop;
   logic w_push_ok;
   logic w_push_drop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == DEPTH_C);
   assign o_valid = !o_empty;
   assign o_count = r_count;
   assign o_ovf   = r_ovf;
   assign o_data  = o_empty ? '0 : r_mem[r_rptr];

   // A pop on a full FIFO frees the head slot at the same edge, so the push may land there.
   assign w_pop       = o_valid && i_ready;
   assign w_push_ok   = i_push && (!o_full || w_pop);
   assign w_push_drop = i_push && !w_push_ok;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Set has priority over clear when both happen in one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
      end else if (w_push_drop) begin
         r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM plus I/O page (output FIFO, STATUS, free-running CYCLE counter).
// Define DMEM_BUS_ERR_EN to add the sticky bus_err output mirrored in STATUS[12].
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          RAM_AW     = 8,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] IO_BASE    = 16'hFF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Address_dm,
   input  logic [15:0] Data_dm,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [15:0] ReadData_dm,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
`ifdef DMEM_BUS_ERR_EN
  ,output logic        bus_err
`endif
);

   localparam int RAM_WORDS = 1 << RAM_AW;
   localparam int FIFO_CW   = $clog2(FIFO_DEPTH) + 1;

   logic w_ram_sel;
   logic w_io_page;
   logic w_fifo_sel;
   logic w_status_sel;
   logic w_cycle_sel;
   logic w_unmapped;

   logic [15:0]        r_ram [0:RAM_WORDS-1];
   logic [15:0]        w_ram_rdata;
   logic [15:0]        r_cycle;
   logic [15:0]        w_status;
   logic [15:0]        w_rdata;
   logic [FIFO_CW-1:0] w_fifo_count;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic               w_fifo_ovf;
   logic               w_berr_bit;

   // RAM decode wins over the I/O page in case IO_BASE ever overlaps the RAM range.
   assign w_ram_sel    = (Address_dm[15:RAM_AW] == '0);
   assign w_io_page    = !w_ram_sel && (Address_dm[15:8] == IO_BASE[15:8]);
   assign w_fifo_sel   = w_io_page && (Address_dm[7:0] == FIFO_DATA_OFS);
   assign w_status_sel = w_io_page && (Address_dm[7:0] == STATUS_OFS);
   assign w_cycle_sel  = w_io_page && (Address_dm[7:0] == CYCLE_OFS);
   assign w_unmapped   = !(w_ram_sel || w_fifo_sel || w_status_sel || w_cycle_sel);

   always_ff @(posedge clk) begin
      if (MemWrite && w_ram_sel) begin
         r_ram[Address_dm[RAM_AW-1:0]] <= Data_dm;
      end
   end

   assign w_ram_rdata = r_ram[Address_dm[RAM_AW-1:0]];

   dmem_out_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (16)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (MemWrite && w_fifo_sel),
      .i_wdata   (Data_dm),
      .i_ready   (out_ready),
      .i_ovf_clr (MemWrite && w_status_sel && Data_dm[ST_OVF_BIT]),
      .o_data    (out_data),
      .o_valid   (out_valid),
      .o_count   (w_fifo_count),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_ovf     (w_fifo_ovf)
   );

   // A store to CYCLE replaces that cycle's increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cycle <= '0;
      end else if (MemWrite && w_cycle_sel) begin
         r_cycle <= Data_dm;
      end else begin
         r_cycle <= r_cycle + 16'd1;
      end
   end

`ifdef DMEM_BUS_ERR_EN
   logic r_bus_err;
   logic w_berr_set;
   logic w_berr_clr;

   // FIFO_DATA is write-only, so a simultaneous load there is flagged as a bus fault.
   assign w_berr_set = ((MemRead || MemWrite) && w_unmapped)
                     || (MemWrite && MemRead && w_fifo_sel);
   assign w_berr_clr = MemWrite && w_status_sel && Data_dm[ST_FULL_BIT];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bus_err <= 1'b0;
      end else if (w_berr_set) begin
         r_bus_err <= 1'b1;
      end else if (w_berr_clr) begin
         r_bus_err <= 1'b0;
      end
   end

   assign bus_err    = r_bus_err;
   assign w_berr_bit = r_bus_err;
`else
   assign w_berr_bit = 1'b0;
`endif

   always_comb begin
      w_status                   = '0;
      w_status[ST_OVF_BIT]       = w_fifo_ovf;
      w_status[ST_FULL_BIT]      = w_fifo_full;
      w_status[ST_EMPTY_BIT]     = w_fifo_empty;
      w_status[ST_BERR_BIT]      = w_berr_bit;
      w_status[FIFO_CW-1:0]      = w_fifo_count;
   end

   always_comb begin
      w_rdata = 16'h0000;
      if (MemRead) begin
         if (w_ram_sel) begin
            w_rdata = w_ram_rdata;
         end else if (w_status_sel) begin
            w_rdata = w_status;
         end else if (w_cycle_sel) begin
            w_rdata = r_cycle;
         end
      end
   end

   assign ReadData_dm = w_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (RAM, FIFO, STATUS, CYCLE, async reset).
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic [15:0] Address_dm;
   logic [15:0] Data_dm;
   logic        MemRead;
   logic        MemWrite;
   logic [15:0] ReadData_dm;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
`ifdef DMEM_BUS_ERR_EN
   logic        bus_err;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   dmem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .Address_dm  (Address_dm),
      .Data_dm     (Data_dm),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .ReadData_dm (ReadData_dm),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
`ifdef DMEM_BUS_ERR_EN
     ,.bus_err     (bus_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_bus(input logic we, input logic re, input logic [15:0] a, input logic [15:0] d);
      MemWrite   = we;
      MemRead    = re;
      Address_dm = a;
      Data_dm    = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] v);
      set_bus(1'b0, 1'b1, a, 16'h0000);
      v = ReadData_dm;
   endtask

   task automatic push(input logic [15:0] d);
      set_bus(1'b1, 1'b0, 16'hFF00, d);
      tick();
   endtask

   logic [15:0] v;
   logic [15:0] c0;
   logic [15:0] c1;
   logic [15:0] exp_q [8];

   initial begin
      rst        = 1'b1;
      out_ready  = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      Address_dm = '0;
      Data_dm    = '0;
      #2 rst = 1'b0;
      #1;
      chk("rst_valid", {15'd0, out_valid}, 16'h0000);
      chk("rst_data", out_data, 16'h0000);
      rd(16'hFF01, v); chk("rst_status", v, 16'h2000);
      rd(16'hFF02, v); chk("rst_cycle", v, 16'h0000);
      tick(); tick();
      rst = 1'b1;

      // RAM write/read, read-before-write on the same cycle
      set_bus(1'b1, 1'b0, 16'h0005, 16'hBEEF); tick();
      rd(16'h0005, v); chk("ram_rd", v, 16'hBEEF);
      set_bus(1'b0, 1'b0, 16'h0005, 16'h0000); chk("rd_idle_zero", ReadData_dm, 16'h0000);
      set_bus(1'b1, 1'b1, 16'h0005, 16'h1234); chk("ram_rw_old", ReadData_dm, 16'hBEEF);
      tick();
      rd(16'h0005, v); chk("ram_rw_new", v, 16'h1234);
      set_bus(1'b1, 1'b0, 16'h00FF, 16'h7E7E); tick();
      rd(16'h00FF, v); chk("ram_top", v, 16'h7E7E);

      // FIFO basic push and ordered drain
      push(16'h00A1); push(16'h00A2); push(16'h00A3);
      rd(16'hFF01, v); chk("st_three", v, 16'h0003);
      chk("head_a1", out_data, 16'h00A1);
      rd(16'hFF00, v); chk("fifo_rd_zero", v, 16'h0000);
      out_ready = 1'b1;
      set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("pop_a1", out_data, 16'h00A1); tick();
      chk("pop_a2", out_data, 16'h00A2); tick();
      chk("pop_a3", out_data, 16'h00A3); tick();
      out_ready = 1'b0;
      rd(16'hFF01, v); chk("st_drained", v, 16'h2000);
      chk("valid_low", {15'd0, out_valid}, 16'h0000);

      // Overflow, sticky flag clear, push-with-pop on full
      for (int i = 0; i < 8; i++) push(16'h00B0 + 16'(i));
      push(16'h00BF);
      rd(16'hFF01, v); chk("st_overflow", v, 16'hC008);
      chk("head_b0", out_data, 16'h00B0);
      set_bus(1'b1, 1'b0, 16'hFF01, 16'h0000); tick();
      rd(16'hFF01, v); chk("st_noclr", v, 16'hC008);
      set_bus(1'b1, 1'b0, 16'hFF01, 16'h8000); tick();
      rd(16'hFF01, v); chk("st_ovf_clr", v, 16'h4008);
      out_ready = 1'b1;
      push(16'h00C9);
      out_ready = 1'b0;
      rd(16'hFF01, v); chk("st_full_pp", v, 16'h4008);
      for (int i = 0; i < 7; i++) exp_q[i] = 16'h00B1 + 16'(i);
      exp_q[7] = 16'h00C9;
      out_ready = 1'b1;
      set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d", i), out_data, exp_q[i]);
         tick();
      end
      out_ready = 1'b0;
      rd(16'hFF01, v); chk("st_empty2", v, 16'h2000);

      // CYCLE counter rate, load and wrap
      rd(16'hFF02, c0);
      for (int i = 0; i < 10; i++) tick();
      rd(16'hFF02, c1);
      chk("cyc_delta", c1 - c0, 16'd10);
      set_bus(1'b1, 1'b0, 16'hFF02, 16'hFFFE); tick();
      rd(16'hFF02, v); chk("cyc_load", v, 16'hFFFE);
      tick();
      rd(16'hFF02, v); chk("cyc_ffff", v, 16'hFFFF);
      tick();
      rd(16'hFF02, v); chk("cyc_wrap", v, 16'h0000);

      // Unmapped addresses
      set_bus(1'b1, 1'b0, 16'h0000, 16'h0F0F); tick();
      rd(16'h8000, v); chk("unmap_rd", v, 16'h0000);
      rd(16'hFF03, v); chk("unmap_ff03", v, 16'h0000);
      set_bus(1'b1, 1'b0, 16'h8000, 16'h5555); tick();
      set_bus(1'b1, 1'b0, 16'h0100, 16'hAAAA); tick();
      rd(16'h0000, v); chk("ram_noalias", v, 16'h0F0F);
      rd(16'h0100, v); chk("unmap_0100", v, 16'h0000);
`ifdef DMEM_BUS_ERR_EN
      chk("berr_set", {15'd0, bus_err}, 16'h0001);
      rd(16'hFF01, v); chk("st_berr", v, 16'h3000);
      set_bus(1'b1, 1'b0, 16'hFF01, 16'h4000); tick();
      chk("berr_clr", {15'd0, bus_err}, 16'h0000);
      set_bus(1'b1, 1'b1, 16'hFF00, 16'h0077); tick();
      chk("berr_fiforw", {15'd0, bus_err}, 16'h0001);
      set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
`else
      rd(16'hFF01, v); chk("st_noberr", v, 16'h2000);
`endif

      // Asynchronous reset with words queued
      push(16'h00D0); push(16'h00D1); push(16'h00D2); push(16'h00D3);
      rd(16'hFF01, v); chk("st_four", v, 16'h0004);
      set_bus(1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("pre_rst_valid", {15'd0, out_valid}, 16'h0001);
      rst = 1'b0;
      #1;
      chk("async_valid", {15'd0, out_valid}, 16'h0000);
      chk("async_data", out_data, 16'h0000);
      tick();
      rst = 1'b1;
      rd(16'hFF01, v); chk("st_post_rst", v, 16'h2000);
      rd(16'hFF02, v); chk("cyc_post_rst", v, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
